// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES definitions for the key-schedule slice:
//   NR       - number of AES-128 rounds
//   round_t  - 4-bit round index (0..10)
//   word_t   - 32-bit key-schedule word
//   rcon()   - round constant lookup, round index -> byte (00 outside 1..10)
//   rot_word - cyclic byte rotation {b1,b2,b3,b0}
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int NR = 10;

    typedef logic [3:0]  round_t;
    typedef logic [31:0] word_t;

    function automatic logic [7:0] rcon(input round_t idx);
        logic [7:0] rc;
        case (idx)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// ---------------------------------------------------------------------------
// aes_sbox
// Forward AES S-box, purely combinational byte lookup. The same primitive is
// used by the SubBytes stage of the round datapath.
//   din  - input byte
//   dout - substituted byte
// ---------------------------------------------------------------------------
module aes_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign dout = SBOX[din];

endmodule

// File: rtl/aes_sub_word.sv
// ---------------------------------------------------------------------------
// aes_sub_word
// Combinational SubWord: applies the S-box to each byte of a 32-bit word.
//   w_in  - input word
//   w_out - byte-wise substituted word
// ---------------------------------------------------------------------------
module aes_sub_word
    import aes_pkg::*;
(
    input  word_t w_in,
    output word_t w_out
);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
            aes_sbox u_sbox (
                .din  (w_in[8*gi +: 8]),
                .dout (w_out[8*gi +: 8])
            );
        end
    endgenerate

endmodule

// File: rtl/aes128_key_sched_seq.sv
// ---------------------------------------------------------------------------
// aes128_key_sched_seq
// Iterative AES-128 key expansion. A cipher key is taken on a key_valid /
// key_ready handshake and round keys are then handed out one per rk_valid /
// rk_ready transfer, at most one per cycle, finishing with round 10.
//   clk, rst_n           - clock (rising edge), asynchronous active-low reset
//   key_in, key_valid    - cipher key input (w0 = [127:96])
//   key_ready            - idle and able to accept a key
//   rk_out, rk_round     - current round key and its round index
//   rk_valid, rk_ready   - round key handshake
//   busy                 - expansion in progress
// EMIT_ROUND0 = 1 hands out the raw key as round 0 first; 0 starts at round 1.
// ---------------------------------------------------------------------------
module aes128_key_sched_seq #(
    parameter bit EMIT_ROUND0 = 1'b1,
    parameter int NR          = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         busy
);

    import aes_pkg::round_t;
    import aes_pkg::word_t;
    import aes_pkg::rcon;
    import aes_pkg::rot_word;

    generate
        if (NR != aes_pkg::NR) begin : g_bad_nr
            $error("aes128_key_sched_seq supports AES-128 only (NR must be 10)");
        end
    endgenerate

    typedef enum logic {IDLE, EMIT} state_t;

    state_t       state_reg;
    logic [127:0] rk_out_reg;
    round_t       rk_round_reg;
    logic         rk_valid_reg;
    logic         busy_reg;

    // The expansion reads the incoming key while idle (only used when round 0
    // is skipped) and the held round key otherwise, so one SubWord serves both.
    logic [127:0] src_key;
    logic [127:0] nxt_key;
    round_t       nxt_round;
    word_t        src_w [4];
    word_t        nxt_w [4];
    word_t        sub_out;
    word_t        t_word;

    assign src_key   = (state_reg == IDLE) ? key_in : rk_out_reg;
    assign nxt_round = (state_reg == IDLE) ? round_t'(1) : rk_round_reg + round_t'(1);

    aes_sub_word u_sub_word (
        .w_in  (rot_word(src_w[3])),
        .w_out (sub_out)
    );

    assign t_word = sub_out ^ {rcon(nxt_round), 24'h000000};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_words
            assign src_w[gi] = src_key[127-32*gi -: 32];
            if (gi == 0) begin : g_first
                assign nxt_w[gi] = src_w[gi] ^ t_word;
            end else begin : g_chain
                assign nxt_w[gi] = src_w[gi] ^ nxt_w[gi-1];
            end
        end
    endgenerate

    assign nxt_key = {nxt_w[0], nxt_w[1], nxt_w[2], nxt_w[3]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            rk_out_reg   <= '0;
            rk_round_reg <= '0;
            rk_valid_reg <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (key_valid) begin
                        state_reg    <= EMIT;
                        rk_valid_reg <= 1'b1;
                        busy_reg     <= 1'b1;
                        if (EMIT_ROUND0) begin
                            rk_out_reg   <= key_in;
                            rk_round_reg <= round_t'(0);
                        end else begin
                            rk_out_reg   <= nxt_key;
                            rk_round_reg <= round_t'(1);
                        end
                    end
                end
                EMIT: begin
                    if (rk_valid_reg && rk_ready) begin
                        if (rk_round_reg == round_t'(aes_pkg::NR)) begin
                            // Last key stays on rk_out/rk_round after the transfer.
                            state_reg    <= IDLE;
                            rk_valid_reg <= 1'b0;
                            busy_reg     <= 1'b0;
                        end else begin
                            rk_out_reg   <= nxt_key;
                            rk_round_reg <= nxt_round;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign key_ready = (state_reg == IDLE);
    assign rk_out    = rk_out_reg;
    assign rk_round  = rk_round_reg;
    assign rk_valid  = rk_valid_reg;
    assign busy      = busy_reg;

endmodule

// File: doc/aes128_key_sched_seq.md
Name: aes128_key_sched_seq

Overview:
- Iterative AES-128 key schedule that expands one 128-bit cipher key into round keys 0..10.
- Emits one round key per handshake, at up to one per cycle.
- Feeds the AddRoundKey stage that sits directly ahead of the SubBytes stage in the round datapath.
- Shares the sbox byte-substitution primitive with SubBytes, through a SubWord sub-module.

Parameters:
- EMIT_ROUND0, 1, 1 = round key 0 (the raw cipher key) is emitted first; 0 = emission starts at round 1.
- NR, 10, number of rounds; fixed at 10 (AES-128 only); any other value is a configuration error.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- key_in  in  128  cipher key; byte 0 at [127:120]; w0 = [127:96], w3 = [31:0].
- key_valid  in  1  key_in is valid.
- key_ready  out  1  block idle and able to accept a key.
- rk_out  out  128  current round key, same byte and word ordering as key_in.
- rk_round  out  4  round index of rk_out, range 0..10.
- rk_valid  out  1  rk_out/rk_round are valid.
- rk_ready  in  1  consumer accepts the round key.
- busy  out  1  expansion in progress.

Behaviour:
- Reset values (asynchronous, on rst_n low):
  - State = IDLE.
  - rk_out = 0, rk_round = 0, rk_valid = 0, busy = 0.
  - key_ready = 1 once rst_n deasserts.
- States:
  - IDLE: key_ready = 1, rk_valid = 0. On key_valid & key_ready, load the key register and go to EMIT.
    - EMIT_ROUND0 = 1: rk_out = key_in, rk_round = 0.
    - EMIT_ROUND0 = 0: rk_out = expansion of key_in, rk_round = 1.
    - The EMIT_ROUND0 = 0 case makes the first round computation a combinational path from key_in to register.
  - EMIT: rk_valid = 1, busy = 1, key_ready = 0.
    - On rk_valid & rk_ready with rk_round < 10: register the next round key and increment rk_round. rk_valid stays high.
    - On rk_valid & rk_ready with rk_round = 10: go to IDLE. rk_valid = 0 and busy = 0 on the next cycle; rk_out and rk_round hold their last value.
- Latency and throughput:
  - Key accepted at edge N; first round key valid from cycle N+1.
  - With rk_ready held at 1, round 10 is transferred at edge N+11 (N+10 when EMIT_ROUND0 = 0).
  - One round key per cycle.
- Stall: while rk_valid = 1 and rk_ready = 0, rk_out and rk_round are held stable. AXI-style: valid does not drop without a transfer.
- Expansion step, from current words w0..w3 and round r (r = round being produced, 1..10):
  - t = SubWord(RotWord(w3)) XOR {RCON[r], 24'h0}.
  - RotWord: {b1,b2,b3,b0}.
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
- RCON[1..10] = 01,02,04,08,10,20,40,80,1b,36.
  - The index is derived from rk_round + 1, never from a free-running counter.
  - Index 11 is unreachable; any out-of-range index yields 00.
- key_valid while busy: ignored, no capture (key_ready = 0). Consumer readiness has no effect on key_ready.
- Key arriving on the same cycle as the round-10 transfer: not accepted. key_ready rises the cycle after return to IDLE, so back-to-back keys cost one idle cycle.
- rk_ready asserted while rk_valid = 0: no effect.
- Reset asserted mid-expansion: immediate abort to the reset values; no partial key is reissued after release.
- No combinational path from rk_ready to rk_valid or rk_out. key_ready depends only on state.

Decomposition:
- Shared package aes_pkg:
  - NR = 10 and a 4-bit round-index type.
  - RCON lookup function (round index -> byte).
  - 32-bit word type.
  - RotWord function.
- Sub-module aes_sub_word: 32-bit combinational SubWord made of four sbox instances. It is the only S-box user in this block.
- The state machine, the key register and the expansion XOR chain stay in aes128_key_sched_seq.

Test Plan:
1. FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready = 1, EMIT_ROUND0 = 1 -> 11 consecutive valid cycles:
   - rk_round 0 = key.
   - rk_round 1 = a0fafe1788542cb123a339392a6c7605.
   - rk_round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
   - Then rk_valid = 0 and key_ready = 1.
2. All-zero key -> round 1 = 62636363626363636263636362636363, round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
3. Backpressure: same key as test 1, rk_ready toggled randomly -> identical sequence of 11 keys; rk_out and rk_round stable during every stall cycle.
4. key_valid held high with new key 000102030405060708090a0b0c0d0e0f during an active expansion -> ignored; second key accepted exactly one cycle after the round-10 transfer; its round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
5. rst_n pulsed low at round 4 -> rk_valid = 0, rk_out = 0, key_ready = 1 immediately after release; a fresh key expands correctly.
6. EMIT_ROUND0 = 0, test 1 key -> first output is rk_round 1 = a0fafe17...; exactly 10 transfers, the last being round 10.
